// File: rtl/fetch_align_queue_pkg.sv
// Shared types and constants for the fetch/align queue: FSM state encoding,
// the halt instruction, and small PC/halfword helpers.
package common;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam logic [31:0] HALT_WORD = 32'h0000_1111;

  function automatic logic [31:0] next_word_pc(input logic [31:0] pc);
    return {pc[31:2] + 30'd1, 2'b00};
  endfunction

  // RISC-V length rule: only low bits 2'b11 start a 32-bit instruction.
  function automatic logic hw_is_compressed(input logic [15:0] hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_align_queue_fifo.sv
// Circular halfword queue: up to two halfwords pushed and popped per cycle,
// with a two-entry head peek so a 32-bit instruction can straddle the wrap.
module halfword_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic [1:0]             push_cnt,
  input  logic [15:0]            push_hw0,
  input  logic [15:0]            push_hw1,
  input  logic [1:0]             pop_cnt,
  output logic [15:0]            peek_hw0,
  output logic [15:0]            peek_hw1,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int AW = $clog2(DEPTH);

  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [AW-1:0] w_wr_ptr1;
  logic [AW-1:0] w_rd_ptr1;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  assign w_wr_ptr1 = r_wr_ptr + AW'(1);
  assign w_rd_ptr1 = r_rd_ptr + AW'(1);

  always_ff @(posedge clk) begin
    if (push_cnt != 2'd0) r_mem[r_wr_ptr]  <= push_hw0;
    if (push_cnt == 2'd2) r_mem[w_wr_ptr1] <= push_hw1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(push_cnt);
      r_rd_ptr <= r_rd_ptr + AW'(pop_cnt);
      r_count  <= r_count + (AW+1)'(push_cnt) - (AW+1)'(pop_cnt);
    end
  end

  assign peek_hw0  = r_mem[r_rd_ptr];
  assign peek_hw1  = r_mem[w_rd_ptr1];
  assign occupancy = r_count;

endmodule

// File: rtl/fetch_align_queue.sv
// Instruction fetch front end: issues word fetches, queues returned halfwords
// and presents whole (16- or 32-bit) instructions with their PC to decode.
module fetch_align_queue
  import common::*;
#(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   run_en,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic                   mem_req,
  output logic [31:0]            mem_addr,
  input  logic                   mem_rvalid,
  input  logic [31:0]            mem_rdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_instr,
  output logic [31:0]            out_pc,
  output logic                   out_compressed,
  output logic                   halted,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [1:0]             dbg_state
);

  localparam int OW = $clog2(DEPTH) + 1;

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [31:0]  r_fetch_pc;
  logic [31:0]  r_head_pc;
  logic         r_epoch;
  logic         r_inflight;
  logic         r_inflight_epoch;
  logic         r_inflight_hi;

  logic [15:0]  w_peek0;
  logic [15:0]  w_peek1;
  logic [OW-1:0] w_occ;
  logic [OW:0]  w_need;
  logic         w_space_ok;
  logic         w_head_comp;
  logic [31:0]  w_instr;
  logic         w_out_valid;
  logic         w_accept;
  logic         w_mem_req;
  logic         w_resp_ok;
  logic [1:0]   w_push_cnt;
  logic [15:0]  w_push_hw0;
  logic [1:0]   w_pop_cnt;
  logic [31:0]  w_redirect_al;
  logic         w_unused_ok;

  assign w_redirect_al = {redirect_pc[31:1], 1'b0};
  assign w_unused_ok   = &{1'b0, redirect_pc[0], r_fetch_pc[0]};

  // Fetch only while the queue can absorb this word plus any word still in flight.
  assign w_need     = {1'b0, w_occ} + (r_inflight ? (OW+1)'(4) : (OW+1)'(2));
  assign w_space_ok = w_need <= (OW+1)'(DEPTH);

  // out_valid/out_ready: an instruction transfers on any cycle both are high;
  // while out_valid is high and out_ready low the head is held unchanged.
  always_comb begin
    w_head_comp = hw_is_compressed(w_peek0);
    w_instr     = w_head_comp ? {16'h0000, w_peek0} : {w_peek1, w_peek0};
    w_out_valid = (r_state == RUN) && !redirect_valid &&
                  (((w_occ >= OW'(1)) && w_head_comp) || (w_occ >= OW'(2)));
    w_accept    = w_out_valid && out_ready;
    w_pop_cnt   = w_accept ? (w_head_comp ? 2'd1 : 2'd2) : 2'd0;
    w_mem_req   = (r_state == RUN) && !redirect_valid && w_space_ok;
    w_resp_ok   = mem_rvalid && r_inflight && (r_inflight_epoch == r_epoch) &&
                  !redirect_valid;
    w_push_cnt  = w_resp_ok ? (r_inflight_hi ? 2'd1 : 2'd2) : 2'd0;
    w_push_hw0  = r_inflight_hi ? mem_rdata[31:16] : mem_rdata[15:0];
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (run_en) w_state_nxt = RUN;
      RUN:     if (w_accept && (w_instr == HALT_WORD)) w_state_nxt = HALTED;
      HALTED:  if (redirect_valid) w_state_nxt = RUN;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state          <= IDLE;
      r_fetch_pc       <= RESET_PC;
      r_head_pc        <= RESET_PC;
      r_epoch          <= 1'b0;
      r_inflight       <= 1'b0;
      r_inflight_epoch <= 1'b0;
      r_inflight_hi    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_mem_req;
      if (w_mem_req) begin
        r_inflight_epoch <= r_epoch;
        r_inflight_hi    <= r_fetch_pc[1];
      end
      if (redirect_valid) begin
        r_fetch_pc <= w_redirect_al;
        r_head_pc  <= w_redirect_al;
        r_epoch    <= ~r_epoch;
      end else begin
        if (w_mem_req) r_fetch_pc <= next_word_pc(r_fetch_pc);
        if (w_accept)  r_head_pc  <= r_head_pc + (w_head_comp ? 32'd2 : 32'd4);
      end
    end
  end

  halfword_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (redirect_valid),
    .push_cnt  (w_push_cnt),
    .push_hw0  (w_push_hw0),
    .push_hw1  (mem_rdata[31:16]),
    .pop_cnt   (w_pop_cnt),
    .peek_hw0  (w_peek0),
    .peek_hw1  (w_peek1),
    .occupancy (w_occ)
  );

  assign mem_req        = w_mem_req;
  assign mem_addr       = {r_fetch_pc[31:2], 2'b00};
  assign out_valid      = w_out_valid;
  assign out_instr      = w_instr;
  assign out_pc         = r_head_pc;
  assign out_compressed = w_head_comp;
  assign halted         = (r_state == HALTED);
  assign occupancy      = w_occ;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_fetch_align_queue.sv
// Directed bench for fetch_align_queue: a per-cycle vector table for the
// first fetch stream, then hand sequences for backpressure, redirect, halt, reset.
module tb_fetch_align_queue;
  import common::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        run_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_compressed;
  logic        halted;
  logic [3:0]  occupancy;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  fetch_align_queue #(.DEPTH(8), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .run_en         (run_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_compressed (out_compressed),
    .halted         (halted),
    .occupancy      (occupancy),
    .dbg_state      (dbg_state)
  );

  typedef struct {
    logic        run_en;
    logic        out_ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_instr;
    logic        exp_comp;
    logic [31:0] exp_pc;
    logic [3:0]  exp_occ;
  } vec_t;

  vec_t        vecs [9];
  logic [31:0] mem_m [logic [31:0]];
  logic [63:0] exp_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        req_seen;
  logic [31:0] addr_seen;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return 32'h0001_0001;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock: sample the request mid-cycle, answer it in the following cycle.
  task automatic tick();
    @(negedge clk);
    req_seen  = mem_req;
    addr_seen = mem_addr;
    @(posedge clk);
    #1;
    mem_rvalid = req_seen;
    mem_rdata  = req_seen ? mem_word(addr_seen) : 32'h0;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    #1;
    chk("redir_cycle_mem_req", 32'(mem_req), 32'd0);
    chk("redir_cycle_out_valid", 32'(out_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
  endtask

  task automatic expect_instr(input logic [31:0] pc, input logic [31:0] instr);
    exp_q.push_back({pc, instr});
  endtask

  task automatic collect(input int n, input int budget);
    int          got = 0;
    int          cyc = 0;
    logic [63:0] e;
    while (got < n && cyc < budget) begin
      #1;
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        chk("out_pc", out_pc, e[63:32]);
        chk("out_instr", out_instr, e[31:0]);
        chk("out_compressed", 32'(out_compressed), 32'(e[1:0] != 2'b11));
        got++;
      end
      tick();
      cyc++;
    end
    chk("collect_count", 32'(got), 32'(n));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    mem_m[32'h0000_0000] = 32'h0041_0513;
    mem_m[32'h0000_0004] = 32'h4505_4501;
    mem_m[32'h0000_0300] = 32'h0001_4501;
    mem_m[32'h0000_0304] = 32'h0513_4505;
    mem_m[32'h0000_0308] = 32'h0041_0093;
    mem_m[32'h0000_030C] = 32'h0513_4511;
    mem_m[32'h0000_0310] = 32'h0001_0041;
    mem_m[32'h0000_0400] = 32'h0513_4501;
    mem_m[32'h0000_0404] = 32'h4505_0041;
    mem_m[32'h0000_0100] = 32'h4505_0513;
    mem_m[32'h0000_0104] = 32'h0001_4511;
    mem_m[32'h0000_0500] = 32'h1111_4501;
    mem_m[32'h0000_0200] = 32'h0001_4509;

    //             run   rdy   req   addr   valid instr          comp  pc     occ
    vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h0000_0000, 1'b0, 32'h00, 4'd0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0000_0000, 1'b0, 32'h00, 4'd0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0000_0000, 1'b0, 32'h00, 4'd0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0041_0513, 1'b0, 32'h00, 4'd2};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h0000_4501, 1'b1, 32'h04, 4'd2};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h0000_4505, 1'b1, 32'h06, 4'd3};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'h0000_0001, 1'b1, 32'h08, 4'd4};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 32'h18, 1'b1, 32'h0000_0001, 1'b1, 32'h0A, 4'd5};
    vecs[8] = '{1'b0, 1'b1, 1'b1, 32'h18, 1'b1, 32'h0000_0001, 1'b1, 32'h0C, 4'd6};

    reset_n        = 1'b0;
    run_en         = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    mem_rvalid     = 1'b0;
    mem_rdata      = 32'h0;
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));

    // First stream straight out of reset, cycle by cycle.
    for (int i = 0; i < 9; i++) begin
      run_en    = vecs[i].run_en;
      out_ready = vecs[i].out_ready;
      #1;
      chk($sformatf("v%0d_mem_req", i), 32'(mem_req), 32'(vecs[i].exp_req));
      chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].exp_addr);
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        chk($sformatf("v%0d_out_instr", i), out_instr, vecs[i].exp_instr);
        chk($sformatf("v%0d_out_comp", i), 32'(out_compressed), 32'(vecs[i].exp_comp));
      end
      chk($sformatf("v%0d_out_pc", i), out_pc, vecs[i].exp_pc);
      chk($sformatf("v%0d_occupancy", i), 32'(occupancy), 32'(vecs[i].exp_occ));
      tick();
    end
    run_en = 1'b0;

    // Backpressure: fill to DEPTH, hold the head, then drain across the wrap.
    out_ready = 1'b0;
    redirect_to(32'h0000_0300);
    w = 0;
    while (occupancy != 4'd8 && w < 20) begin
      tick();
      w++;
    end
    chk("sat_occupancy", 32'(occupancy), 32'd8);
    for (int k = 0; k < 3; k++) begin
      chk("sat_mem_req", 32'(mem_req), 32'd0);
      chk("sat_occ_hold", 32'(occupancy), 32'd8);
      chk("sat_out_valid", 32'(out_valid), 32'd1);
      chk("sat_hold_instr", out_instr, 32'h0000_4501);
      chk("sat_hold_pc", out_pc, 32'h0000_0300);
      tick();
    end
    out_ready = 1'b1;
    expect_instr(32'h300, 32'h0000_4501);
    expect_instr(32'h302, 32'h0000_0001);
    expect_instr(32'h304, 32'h0000_4505);
    expect_instr(32'h306, 32'h0093_0513);
    expect_instr(32'h30A, 32'h0000_0041);
    expect_instr(32'h30C, 32'h0000_4511);
    expect_instr(32'h30E, 32'h0041_0513);
    expect_instr(32'h312, 32'h0000_0001);
    expect_instr(32'h314, 32'h0000_0001);
    collect(9, 80);

    // Redirect latency and a 32-bit instruction straddling two fetched words.
    redirect_to(32'h0000_0401);
    chk("lat1_mem_req", 32'(mem_req), 32'd1);
    chk("lat1_mem_addr", mem_addr, 32'h0000_0400);
    chk("lat1_out_valid", 32'(out_valid), 32'd0);
    tick();
    chk("lat2_out_valid", 32'(out_valid), 32'd0);
    tick();
    chk("lat3_out_valid", 32'(out_valid), 32'd1);
    expect_instr(32'h400, 32'h0000_4501);
    expect_instr(32'h402, 32'h0041_0513);
    expect_instr(32'h406, 32'h0000_4505);
    collect(3, 20);

    // Redirect to a halfword target while a response is in flight.
    w = 0;
    while (!mem_req && w < 10) begin
      tick();
      w++;
    end
    chk("inflight_setup_req", 32'(mem_req), 32'd1);
    tick();
    redirect_to(32'h0000_0102);
    chk("odd_mem_req", 32'(mem_req), 32'd1);
    chk("odd_mem_addr", mem_addr, 32'h0000_0100);
    expect_instr(32'h102, 32'h0000_4505);
    expect_instr(32'h104, 32'h0000_4511);
    expect_instr(32'h106, 32'h0000_0001);
    collect(3, 20);

    // Halt on HALT_WORD, then resume via redirect.
    redirect_to(32'h0000_0500);
    expect_instr(32'h500, 32'h0000_4501);
    expect_instr(32'h502, 32'h0000_1111);
    collect(2, 20);
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_mem_req", 32'(mem_req), 32'd0);
    chk("halt_out_valid", 32'(out_valid), 32'd0);
    chk("halt_state", 32'(dbg_state), 32'(HALTED));
    tick();
    chk("halt2_mem_req", 32'(mem_req), 32'd0);
    chk("halt2_halted", 32'(halted), 32'd1);
    redirect_to(32'h0000_0200);
    chk("resume_halted", 32'(halted), 32'd0);
    chk("resume_state", 32'(dbg_state), 32'(RUN));
    chk("resume_mem_req", 32'(mem_req), 32'd1);
    chk("resume_mem_addr", mem_addr, 32'h0000_0200);
    expect_instr(32'h200, 32'h0000_4509);
    collect(1, 20);

    // Reset in the middle of a fetch; the late response must be dropped.
    w = 0;
    while (!mem_req && w < 10) begin
      tick();
      w++;
    end
    chk("midrst_setup_req", 32'(mem_req), 32'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    #1;
    chk("midrst_mem_req", 32'(mem_req), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_halted", 32'(halted), 32'd0);
    chk("midrst_occupancy", 32'(occupancy), 32'd0);
    chk("midrst_out_pc", out_pc, 32'h0);
    chk("midrst_state", 32'(dbg_state), 32'(IDLE));
    tick();
    chk("midrst_stale_dropped", 32'(occupancy), 32'd0);
    run_en = 1'b1;
    tick();
    run_en = 1'b0;
    expect_instr(32'h000, 32'h0041_0513);
    collect(1, 20);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
